// File: rtl/ibex_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_arb
// Description : Arbiter that lets the Ibex instruction and data hosts share
//               one single-port SRAM with a fixed 1-cycle read latency.
//               - Round-robin arbitration between the two hosts.
//               - Full address decode; requests outside the RAM window get
//                 an error response and never reach the RAM.
//               - Each response is routed back to the host that issued it.
//               Optional build macro IBEX_MEM_ARB_PERF_CNT_EN enables a
//               saturating count of cycles the instruction host was stalled.
// Ports       : clk_i, rst_ni             clock, synchronous active-low reset
//               instr_req/gnt/addr        instruction request channel
//               instr_rvalid/rdata/err    instruction response channel
//               data_req/gnt/we/be/addr/wdata  data request channel
//               data_rvalid/rdata/err     data response channel
//               mem_req/we/be/addr/wdata  RAM request channel
//               mem_rvalid/rdata          RAM response channel
//               instr_stall_cnt_o         instruction stall cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_arb #(
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter int unsigned MemSize  = 65536,
    parameter logic [31:0] MemMask  = 32'(MemSize - 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic [31:0] instr_stall_cnt_o
);

    localparam logic c_host_instr = 1'b0;
    localparam logic c_host_data  = 1'b1;

    logic        w_instr_win;
    logic        w_data_win;
    logic        w_grant;
    logic [31:0] w_addr;
    logic        w_oor;
    logic        w_resp;
    logic        w_instr_resp;
    logic        w_data_resp;
    logic        w_unused_rvalid;

    logic        r_last;
    logic        r_pend;
    logic        r_owner;
    logic        r_oor;

    // Responses are a fixed one cycle after the grant, so the RAM's own
    // valid strobe carries no extra information.
    assign w_unused_rvalid = mem_rvalid_i;

    // Under contention the host that did not win last time gets the slot.
    // Grants are gated by reset so nothing leaves the block while held.
    assign w_instr_win = rst_ni & instr_req_i & (~data_req_i | (r_last == c_host_data));
    assign w_data_win  = rst_ni & data_req_i  & (~instr_req_i | (r_last == c_host_instr));
    assign w_grant     = w_instr_win | w_data_win;

    assign instr_gnt_o = w_instr_win;
    assign data_gnt_o  = w_data_win;

    assign w_addr = w_data_win ? data_addr_i : instr_addr_i;
    assign w_oor  = (w_addr & ~MemMask) != MemStart;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_grant) begin
            // Out-of-range accesses are granted but never touch the RAM.
            mem_req_o  = ~w_oor;
            mem_addr_o = w_addr;
            if (w_data_win) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_we_o    = 1'b0;
                mem_be_o    = 4'hF;
                mem_wdata_o = 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last  <= c_host_instr;
            r_pend  <= 1'b0;
            r_owner <= c_host_instr;
            r_oor   <= 1'b0;
        end else begin
            r_pend <= w_grant;
            if (w_grant) begin
                r_last  <= w_data_win;
                r_owner <= w_data_win;
                r_oor   <= w_oor;
            end
        end
    end

    // A reset arriving while a response is pending suppresses it at once.
    assign w_resp       = rst_ni & r_pend;
    assign w_instr_resp = w_resp & (r_owner == c_host_instr);
    assign w_data_resp  = w_resp & (r_owner == c_host_data);

    assign instr_rvalid_o = w_instr_resp;
    assign instr_err_o    = w_instr_resp & r_oor;
    assign instr_rdata_o  = (w_instr_resp & ~r_oor) ? mem_rdata_i : 32'h0;

    assign data_rvalid_o  = w_data_resp;
    assign data_err_o     = w_data_resp & r_oor;
    assign data_rdata_o   = (w_data_resp & ~r_oor) ? mem_rdata_i : 32'h0;

`ifdef IBEX_MEM_ARB_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall_cnt <= 32'h0;
        end else if (instr_req_i && !instr_gnt_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'h1;
        end
    end

    assign instr_stall_cnt_o = rst_ni ? r_stall_cnt : 32'h0;
`else
    assign instr_stall_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_mem_arb
// Description : Self-checking bench for ibex_mem_arb. A reference model
//               predicts grants, RAM requests and responses; expectations
//               are queued and a negedge monitor compares them with the DUT.
//               A behavioural RAM answers the DUT's RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_mem_arb;

    localparam logic [31:0] c_mem_start = 32'h0000_0000;
    localparam int unsigned c_mem_size  = 65536;
    localparam int          c_words     = c_mem_size / 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic [31:0] instr_stall_cnt_o;

    always #5 clk_i = ~clk_i;

    ibex_mem_arb #(
        .MemStart (c_mem_start),
        .MemSize  (c_mem_size)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .instr_req_i       (instr_req_i),
        .instr_gnt_o       (instr_gnt_o),
        .instr_addr_i      (instr_addr_i),
        .instr_rvalid_o    (instr_rvalid_o),
        .instr_rdata_o     (instr_rdata_o),
        .instr_err_o       (instr_err_o),
        .data_req_i        (data_req_i),
        .data_gnt_o        (data_gnt_o),
        .data_we_i         (data_we_i),
        .data_be_i         (data_be_i),
        .data_addr_i       (data_addr_i),
        .data_wdata_i      (data_wdata_i),
        .data_rvalid_o     (data_rvalid_o),
        .data_rdata_o      (data_rdata_o),
        .data_err_o        (data_err_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_be_o          (mem_be_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i),
        .instr_stall_cnt_o (instr_stall_cnt_o)
    );

    typedef struct {
        bit          ig;
        bit          dg;
        bit          mreq;
        bit          mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } gnt_t;

    typedef struct {
        bit          host;   // 0 = instr, 1 = data
        bit          err;
        bit          chkd;   // compare rdata
        logic [31:0] rdata;
    } rsp_t;

    gnt_t        gq[$];
    rsp_t        rq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ram [c_words];
    logic [31:0] model_mem [c_words];
    int          last_host = 0;
    bit          pend_v = 1'b0;
    rsp_t        pend_r;
    logic [31:0] stall_model = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk_i) begin
        mem_rvalid_i <= 1'b0;
        mem_rdata_i  <= $urandom;
        if (mem_req_o === 1'b1) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b])
                        ram[int'((mem_addr_o - c_mem_start) >> 2)][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rvalid_i <= 1'b1;
                mem_rdata_i  <= ram[int'((mem_addr_o - c_mem_start) >> 2)];
            end
        end
    end

    // Monitor: grant expectations are consumed every stimulus cycle,
    // response expectations whenever one is due.
    always @(negedge clk_i) begin
        gnt_t g;
        rsp_t r;
        bit   have;
        if (gq.size() > 0) begin
            g = gq.pop_front();
            chk("instr_gnt", 32'(instr_gnt_o), 32'(g.ig));
            chk("data_gnt", 32'(data_gnt_o), 32'(g.dg));
            chk("mem_req", 32'(mem_req_o), 32'(g.mreq));
            chk("mem_we", 32'(mem_we_o), 32'(g.mwe));
            chk("mem_be", 32'(mem_be_o), 32'(g.mbe));
            chk("mem_addr", mem_addr_o, g.maddr);
            chk("mem_wdata", mem_wdata_o, g.mwdata);
        end
        have = (rq.size() > 0);
        if (have) r = rq.pop_front();
        else r = '{host: 1'b0, err: 1'b0, chkd: 1'b0, rdata: 32'h0};
        chk("instr_rvalid", 32'(instr_rvalid_o), 32'(have && !r.host));
        chk("data_rvalid", 32'(data_rvalid_o), 32'(have && r.host));
        chk("instr_err", 32'(instr_err_o), 32'(have && !r.host && r.err));
        chk("data_err", 32'(data_err_o), 32'(have && r.host && r.err));
        if (have && !r.host) begin
            if (r.chkd) chk("instr_rdata", instr_rdata_o, r.rdata);
        end else begin
            chk("instr_rdata_idle", instr_rdata_o, 32'h0);
        end
        if (have && r.host) begin
            if (r.chkd) chk("data_rdata", data_rdata_o, r.rdata);
        end else begin
            chk("data_rdata_idle", data_rdata_o, 32'h0);
        end
    end

    // One clock of stimulus plus the model's prediction for it.
    task automatic cycle(input bit run, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dwd);
        gnt_t        g;
        rsp_t        r;
        int          win;
        int          idx;
        logic [31:0] a;
        logic [31:0] w;
        bit          oor;
        @(posedge clk_i);
        #1;
`ifdef IBEX_MEM_ARB_PERF_CNT_EN
        chk("stall_cnt", instr_stall_cnt_o, stall_model);
`else
        chk("stall_cnt", instr_stall_cnt_o, 32'h0);
`endif
        rst_ni       = run;
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = da;
        data_wdata_i = dwd;

        // The previous cycle's grant answers now unless reset is held.
        if (pend_v && run) rq.push_back(pend_r);
        pend_v = 1'b0;

        g = '{ig: 1'b0, dg: 1'b0, mreq: 1'b0, mwe: 1'b0, mbe: 4'h0, maddr: 32'h0, mwdata: 32'h0};
        win = -1;
        if (!run) last_host = 0;
        else if (ir && dr) win = 1 - last_host;
        else if (ir) win = 0;
        else if (dr) win = 1;

        if (!run) stall_model = 32'h0;
        else if (ir && win != 0 && stall_model != 32'hFFFF_FFFF) stall_model = stall_model + 1;

        if (win >= 0) begin
            last_host = win;
            a   = (win == 1) ? da : ia;
            oor = (longint'(a) < longint'(c_mem_start)) ||
                  (longint'(a) - longint'(c_mem_start) >= longint'(c_mem_size));
            g.ig     = (win == 0);
            g.dg     = (win == 1);
            g.mreq   = !oor;
            g.maddr  = a;
            g.mwe    = (win == 1) ? dwe : 1'b0;
            g.mbe    = (win == 1) ? dbe : 4'hF;
            g.mwdata = (win == 1) ? dwd : 32'h0;
            r.host   = (win == 1);
            r.err    = oor;
            r.chkd   = 1'b1;
            r.rdata  = 32'h0;
            if (!oor) begin
                idx = int'((a - c_mem_start) / 4);
                if (win == 1 && dwe) begin
                    w = model_mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (dbe[b]) w[8*b +: 8] = dwd[8*b +: 8];
                    model_mem[idx] = w;
                    r.chkd = 1'b0;
                end else begin
                    r.rdata = model_mem[idx];
                end
            end
            pend_r = r;
            pend_v = 1'b1;
        end
        gq.push_back(g);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h0000_FFFC;
            1:       return 32'h0001_0000;
            2:       return {v[31:2], 2'b00};
            default: return c_mem_start + {16'h0, v[15:2], 2'b00};
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        for (int i = 0; i < c_words; i++) begin
            v = $urandom;
            ram[i]       = v;
            model_mem[i] = v;
        end
        ram[32'h80 >> 2]       = 32'hDEAD_BEEF;
        model_mem[32'h80 >> 2] = 32'hDEAD_BEEF;

        // Reset held with both hosts requesting: nothing may be granted.
        repeat (3) cycle(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        // Contention straight after reset: data, instr, data, instr.
        repeat (4) cycle(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h104, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        // Instruction fetch returning DEADBEEF.
        cycle(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        // Write just past the window: error, no RAM access.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678);
        // Byte write to the last word of the window, then read it back.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h0000_FFFC, 32'h0000_AB00);
        cycle(1'b1, 1'b1, 32'h0000_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0);
        // Grant followed by reset: the response must be dropped and
        // data must win the first conflict afterwards.
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        cycle(1'b1, 1'b1, 32'h84, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), rand_addr(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  rand_addr(), $urandom);
        end

`ifdef IBEX_MEM_ARB_PERF_CNT_EN
        // Counter: reset, ten contended cycles, then saturation.
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (10) cycle(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        @(negedge clk_i);
        release dut.r_stall_cnt;
        stall_model = 32'hFFFF_FFFE;
        repeat (8) cycle(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
`endif

        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", 32'(rq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
